// File: rtl/usb_rx_pkg.sv
// Shared sizing constants and byte type for the USB receive FIFO.
package usb_rx_pkg;

  localparam int FIFO_DEPTH  = 64;
  localparam int FIFO_ADDR_W = 6;
  localparam int FIFO_CNT_W  = 7;

  typedef logic [7:0] usb_byte_t;

endpackage

// File: rtl/usb_rx_fifo_ram.sv
// 64 x 8 storage for the USB receive FIFO: synchronous write, combinational read.
// Contents are intentionally never reset.
module usb_rx_fifo_ram
  import usb_rx_pkg::*;
(
  input  logic                   clk,
  input  logic                   we,
  input  logic [FIFO_ADDR_W-1:0] waddr,
  input  usb_byte_t              wdata,
  input  logic [FIFO_ADDR_W-1:0] raddr,
  output usb_byte_t              rdata
);

  usb_byte_t mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/usb_rx_fifo.sv
// USB receive byte FIFO: first-word fall-through, count-based full/empty,
// sticky overflow, and a receiver-error flush.
module usb_rx_fifo
  import usb_rx_pkg::*;
(
  input  logic                  clk,
  input  logic                  n_rst,
  input  usb_byte_t             rx_data,
  input  logic                  write_enable,
  input  logic                  rcv_error,
  input  logic                  r_enable,
  input  logic                  clear_overflow,
  output usb_byte_t             r_data,
  output logic                  empty,
  output logic                  full,
  output logic [FIFO_CNT_W-1:0] count,
  output logic                  overflow
);

  localparam logic [FIFO_CNT_W-1:0] CNT_FULL = FIFO_CNT_W'(FIFO_DEPTH);

  logic [FIFO_ADDR_W-1:0] wptr_q, wptr_d;
  logic [FIFO_ADDR_W-1:0] rptr_q, rptr_d;
  logic [FIFO_CNT_W-1:0]  count_q, count_d;
  logic                   overflow_q, overflow_d;

  logic is_full, is_empty;
  logic wr_ok, pop_ok, wr_drop;

  always_comb begin
    is_full  = (count_q == CNT_FULL);
    is_empty = (count_q == '0);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write.
    pop_ok  = r_enable && !is_empty && !rcv_error;
    wr_ok   = write_enable && !rcv_error && (!is_full || r_enable);
    wr_drop = write_enable && !rcv_error && is_full && !r_enable;

    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (rcv_error) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_ok) begin
        wptr_d = wptr_q + FIFO_ADDR_W'(1);
      end
      if (pop_ok) begin
        rptr_d = rptr_q + FIFO_ADDR_W'(1);
      end
      case ({wr_ok, pop_ok})
        2'b10:   count_d = count_q + FIFO_CNT_W'(1);
        2'b01:   count_d = count_q - FIFO_CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    // A drop in the same cycle wins over a clear.
    if (wr_drop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  usb_rx_fifo_ram u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wptr_q),
    .wdata (rx_data),
    .raddr (rptr_q),
    .rdata (r_data)
  );

  assign empty    = is_empty;
  assign full     = is_full;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule
